// File: rtl/mmio_host_requester.sv
// rtl/mmio_host_requester.sv - host-side MMIO requester: issues one ha_mm* access, waits for ack or timeout, reports completion
//
// Ports:
//   i_clock, i_reset        sole clock; synchronous active-high reset
//   i_req_*, o_req_ready    host request (valid/ready handshake, fields latched on acceptance)
//   o_mmio_out              ha_mm* bundle toward the AFU (valid, cfg, read, doubleword, address, data, parities)
//   i_mmio_in               ah_mm* bundle from the AFU (ack, data, data_parity)
//   o_rsp_*                 one-cycle completion: data, parity error, timeout
//   o_stray_ack             sticky: an ack arrived while no transaction was waiting for one

package mmio_host_requester_pkg;
  typedef struct packed {
    logic        valid;
    logic        cfg;
    logic        read;
    logic        doubleword;
    logic [23:0] address;
    logic        address_parity;
    logic [63:0] data;
    logic        data_parity;
  } MMIOInterfaceInput;

  typedef struct packed {
    logic        ack;
    logic [63:0] data;
    logic        data_parity;
  } MMIOInterfaceOutput;
endpackage

module mmio_host_requester
  import mmio_host_requester_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_read,
  input  logic               i_req_doubleword,
  input  logic               i_req_cfg,
  input  logic [23:0]        i_req_address,
  input  logic [63:0]        i_req_data,
  output MMIOInterfaceInput  o_mmio_out,
  input  MMIOInterfaceOutput i_mmio_in,
  output logic               o_rsp_valid,
  output logic [63:0]        o_rsp_data,
  output logic               o_rsp_parity_error,
  output logic               o_rsp_timeout,
  output logic               o_stray_ack
);

  localparam logic [15:0] LP_LAST_WAIT = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        w_rsp_read_ok;

  logic        r_cfg;
  logic        r_read;
  logic        r_dw;
  logic [23:0] r_addr;
  logic [63:0] r_data;
  logic [15:0] r_cnt;
  logic [63:0] r_rd_data;
  logic        r_rd_par;
  logic        r_timeout;
  logic        r_stray;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Ack outside WAIT_ACK never alters the normal flow; it only marks stray.
  always_comb begin
    w_next      = r_state;
    o_req_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) w_next = S_ISSUE;
      end
      S_ISSUE:    w_next = S_WAIT_ACK;
      S_WAIT_ACK: begin
        // Ack is tested first so it wins over a timeout in the same cycle.
        if (i_mmio_in.ack)              w_next = S_RESP;
        else if (r_cnt == LP_LAST_WAIT) w_next = S_RESP;
      end
      S_RESP:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  assign w_accept = o_req_ready & i_req_valid;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cfg     <= 1'b0;
      r_read    <= 1'b0;
      r_dw      <= 1'b0;
      r_addr    <= 24'h0;
      r_data    <= 64'h0;
      r_cnt     <= 16'h0;
      r_rd_data <= 64'h0;
      r_rd_par  <= 1'b0;
      r_timeout <= 1'b0;
      r_stray   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cfg     <= i_req_cfg;
        r_read    <= i_req_read;
        r_dw      <= i_req_doubleword;
        r_addr    <= i_req_address;
        // Reads drive zero data; word writes replicate the low word in both halves.
        if (i_req_read)            r_data <= 64'h0;
        else if (i_req_doubleword) r_data <= i_req_data;
        else                       r_data <= {i_req_data[31:0], i_req_data[31:0]};
        r_rd_data <= 64'h0;
        r_rd_par  <= 1'b0;
        r_timeout <= 1'b0;
      end
      if (r_state == S_ISSUE) r_cnt <= 16'h0;
      if (r_state == S_WAIT_ACK) begin
        if (i_mmio_in.ack) begin
          r_rd_data <= i_mmio_in.data;
          r_rd_par  <= i_mmio_in.data_parity;
        end else if (r_cnt == LP_LAST_WAIT) begin
          r_timeout <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 16'h1;
        end
      end
      if (i_mmio_in.ack && (r_state != S_WAIT_ACK)) r_stray <= 1'b1;
    end
  end

  // Everything toward the AFU reads as zero in IDLE, parities included.
  always_comb begin
    o_mmio_out = '0;
    if (r_state != S_IDLE) begin
      o_mmio_out.valid          = (r_state == S_ISSUE);
      o_mmio_out.cfg            = r_cfg;
      o_mmio_out.read           = r_read;
      o_mmio_out.doubleword     = r_dw;
      o_mmio_out.address        = r_addr;
      o_mmio_out.address_parity = ~^r_addr;
      o_mmio_out.data           = r_data;
      o_mmio_out.data_parity    = ~^r_data;
    end
  end

  assign w_rsp_read_ok      = (r_state == S_RESP) && r_read && !r_timeout;
  assign o_rsp_valid        = (r_state == S_RESP);
  assign o_rsp_timeout      = (r_state == S_RESP) && r_timeout;
  assign o_rsp_data         = !w_rsp_read_ok ? 64'h0 :
                              r_dw ? r_rd_data : {32'h0, r_rd_data[31:0]};
  assign o_rsp_parity_error = w_rsp_read_ok && (r_rd_par != ~^r_rd_data);
  assign o_stray_ack        = r_stray;

endmodule

// File: tb/tb_mmio_host_requester.sv
// tb/tb_mmio_host_requester.sv - self-checking bench for mmio_host_requester
module tb_mmio_host_requester;
  import mmio_host_requester_pkg::*;

  localparam int TO   = 8;
  localparam int NONE = 255;

  logic               clk = 1'b0;
  logic               rst;
  logic               req_valid;
  logic               req_ready;
  logic               req_read;
  logic               req_dw;
  logic               req_cfg;
  logic [23:0]        req_addr;
  logic [63:0]        req_data;
  MMIOInterfaceInput  mo;
  MMIOInterfaceOutput mi;
  logic               rsp_valid;
  logic [63:0]        rsp_data;
  logic               rsp_perr;
  logic               rsp_tmo;
  logic               stray;

  always #5 clk = ~clk;

  mmio_host_requester #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clock            (clk),
    .i_reset            (rst),
    .i_req_valid        (req_valid),
    .o_req_ready        (req_ready),
    .i_req_read         (req_read),
    .i_req_doubleword   (req_dw),
    .i_req_cfg          (req_cfg),
    .i_req_address      (req_addr),
    .i_req_data         (req_data),
    .o_mmio_out         (mo),
    .i_mmio_in          (mi),
    .o_rsp_valid        (rsp_valid),
    .o_rsp_data         (rsp_data),
    .o_rsp_parity_error (rsp_perr),
    .o_rsp_timeout      (rsp_tmo),
    .o_stray_ack        (stray)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] data;
    logic        perr;
    logic        tmo;
    logic [63:0] t;
  } rsp_t;
  rsp_t rsp_q[$];

  typedef struct {
    logic        rd;
    logic        dw;
    logic        cfg;
    logic [23:0] addr;
    logic [63:0] wdata;
    int          dly;
    logic [63:0] adata;
    logic        badpar;
  } vec_t;
  vec_t vecs[7];

  // Scoreboard side: every completion must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rsp_valid) begin
      chk("rsp_expected", 64'(rsp_q.size() != 0), 64'd1);
      if (rsp_q.size() != 0) begin
        rsp_t e;
        e = rsp_q.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_parity_error", 64'(rsp_perr), 64'(e.perr));
        chk("rsp_timeout", 64'(rsp_tmo), 64'(e.tmo));
        chk("rsp_time", 64'($time), e.t);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic do_txn(input vec_t v);
    logic [63:0] exp_d;
    logic        ap;
    rsp_t        e;
    int          n;
    exp_d = v.rd ? 64'h0 : (v.dw ? v.wdata : {v.wdata[31:0], v.wdata[31:0]});
    ap    = (~^v.adata) ^ v.badpar;
    @(negedge clk);
    req_valid = 1'b1; req_read = v.rd; req_dw = v.dw; req_cfg = v.cfg;
    req_addr  = v.addr; req_data = v.wdata;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0; req_data = 64'h0; req_addr = 24'h0;
    chk("mmio_valid", 64'(mo.valid), 64'd1);
    chk("mmio_cfg", 64'(mo.cfg), 64'(v.cfg));
    chk("mmio_read", 64'(mo.read), 64'(v.rd));
    chk("mmio_dw", 64'(mo.doubleword), 64'(v.dw));
    chk("mmio_addr", 64'(mo.address), 64'(v.addr));
    chk("mmio_addr_par", 64'(mo.address_parity), 64'(~^v.addr));
    chk("mmio_data", mo.data, exp_d);
    chk("mmio_data_par", 64'(mo.data_parity), 64'(~^exp_d));
    chk("req_ready_busy", 64'(req_ready), 64'd0);
    e.tmo  = (v.dly > TO);
    e.t    = 64'($time) + 64'(10 * (e.tmo ? TO + 1 : v.dly + 1));
    e.data = (e.tmo || !v.rd) ? 64'h0 : (v.dw ? v.adata : {32'h0, v.adata[31:0]});
    e.perr = v.rd && !e.tmo && v.badpar;
    rsp_q.push_back(e);
    @(negedge clk);
    chk("mmio_valid_pulse", 64'(mo.valid), 64'd0);
    chk("mmio_addr_hold", 64'(mo.address), 64'(v.addr));
    if (!e.tmo) begin
      repeat (v.dly - 1) @(negedge clk);
      mi.ack = 1'b1; mi.data = v.adata; mi.data_parity = ap;
      @(negedge clk);
      mi = '0;
    end else begin
      repeat (TO) @(negedge clk);
    end
    chk("mmio_data_hold_resp", mo.data, exp_d);
    @(negedge clk);
    chk("idle_ready", 64'(req_ready), 64'd1);
    chk("idle_addr_zero", 64'(mo.address), 64'h0);
  endtask

  logic [63:0] t1, t2;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_read = 1'b0; req_dw = 1'b0; req_cfg = 1'b0;
    req_addr = 24'h0; req_data = 64'h0; mi = '0;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 24'hFFFFFE, 64'h0123456789ABCDEF, 3, 64'h0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 24'h000000, 64'h0, 2, 64'h12345678_DEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 24'h000123, 64'h0, 1, 64'h1, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 24'h5A5A5A, 64'hFFFF0000_CAFEF00D, 5, 64'h0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 24'h3C3C3C, 64'h0, 8, 64'hA5A55A5A_0F0FF0F0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 24'h7FFFFF, 64'h0, NONE, 64'h0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 24'h000001, 64'h0, 4, 64'h80000000_00000001, 1'b1};

    repeat (2) @(negedge clk);
    chk("reset_ready", 64'(req_ready), 64'd1);
    chk("reset_mmio", 64'(mo), 64'h0);
    chk("reset_mmio_data", mo.data, 64'h0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_stray", 64'(stray), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) do_txn(vecs[i]);
    chk("no_stray_yet", 64'(stray), 64'd0);

    // Late ack while idle after the timeout.
    mi.ack = 1'b1;
    @(negedge clk);
    mi = '0;
    chk("stray_set", 64'(stray), 64'd1);
    chk("stray_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    chk("stray_sticky", 64'(stray), 64'd1);

    // Reset while waiting for ack drops the transaction.
    req_valid = 1'b1; req_read = 1'b1; req_dw = 1'b1; req_addr = 24'h00ABCD;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_issue_valid", 64'(mo.valid), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_mmio_addr", 64'(mo.address), 64'h0);
    chk("rst_stray_clear", 64'(stray), 64'd0);
    repeat (12) @(negedge clk);
    mi.ack = 1'b1; mi.data = 64'hFFFF;
    @(negedge clk);
    mi = '0;
    chk("late_ack_stray", 64'(stray), 64'd1);

    // Back-to-back writes with immediate acks: acceptances 4 cycles apart.
    req_valid = 1'b1; req_read = 1'b0; req_dw = 1'b1; req_cfg = 1'b0;
    req_addr = 24'h000010; req_data = 64'h55;
    t1 = 64'h0; t2 = 64'h0;
    for (int k = 0; k < 2; k++) begin
      int n;
      rsp_t e;
      n = 0;
      @(negedge clk);
      while (!mo.valid && n < 10) begin @(negedge clk); n++; end
      chk("b2b_issue_seen", 64'(mo.valid), 64'd1);
      if (k == 0) t1 = 64'($time); else t2 = 64'($time);
      if (k == 1) req_valid = 1'b0;
      e.data = 64'h0; e.perr = 1'b0; e.tmo = 1'b0; e.t = 64'($time) + 64'd20;
      rsp_q.push_back(e);
      @(negedge clk);
      mi.ack = 1'b1;
      @(negedge clk);
      mi = '0;
    end
    chk("b2b_spacing", t2 - t1, 64'd40);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(rsp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_host_requester.md
MMIO_HOST_REQUESTER -- requirements
Module: mmio_host_requester

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum number of WAIT_ACK cycles before a transaction is abandoned; legal range 1..65535.
REQ-002 Clock and reset are fixed: one clock; reset is synchronous and active-high.
REQ-003 clock  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  a host MMIO request is presented.
REQ-006 req_ready  out  1  the block can accept a request this cycle.
REQ-007 req_read  in  1  1 = read, 0 = write.
REQ-008 req_doubleword  in  1  1 = 64-bit access, 0 = 32-bit access.
REQ-009 req_cfg  in  1  the access targets AFU descriptor space.
REQ-010 req_address  in  24  word address of the access.
REQ-011 req_data  in  64  write data; bits [32:63] carry the word for 32-bit writes.
REQ-012 mmio_out  out  MMIOInterfaceInput  the ha_mm* bundle driven toward the AFU.
REQ-013 mmio_in  in  MMIOInterfaceOutput  the ah_mm* ack/data bundle returned by the AFU.
REQ-014 rsp_valid  out  1  one-cycle completion pulse.
REQ-015 rsp_data  out  64  read data; zero for writes and for timeouts.
REQ-016 rsp_parity_error  out  1  the read-data parity check failed; valid only with rsp_valid.
REQ-017 rsp_timeout  out  1  the transaction timed out; valid only with rsp_valid.
REQ-018 stray_ack  out  1  sticky flag; set by any ack received outside WAIT_ACK.

Function
REQ-019 The state machine SHALL have the states IDLE, ISSUE, WAIT_ACK and RESP, with transitions IDLE->ISSUE->WAIT_ACK->RESP->IDLE.
REQ-020 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted only when req_valid and req_ready are both 1; all request fields SHALL be latched on acceptance.
REQ-021 In ISSUE, mmio_out.valid SHALL be 1 for exactly one cycle, namely the cycle after acceptance; mmio_out.valid SHALL be 0 in every other state.
REQ-022 The mmio_out.cfg, read, doubleword, address and data fields SHALL hold the latched values from ISSUE through RESP and SHALL be 0 in IDLE.
REQ-023 For a 32-bit write, mmio_out.data SHALL equal {req_data[32:63], req_data[32:63]}.
REQ-024 For any read, mmio_out.data SHALL be 0.
REQ-025 mmio_out.address_parity SHALL be odd parity over address (XNOR-reduce).
REQ-026 mmio_out.data_parity SHALL be odd parity over the driven data.
REQ-027 In WAIT_ACK, a 16-bit counter SHALL start at 0 and increment once per cycle.
REQ-028 If mmio_in.ack = 1 is seen in WAIT_ACK, the block SHALL capture the read data and its parity and go to RESP.
REQ-029 If the counter reaches TIMEOUT_CYCLES-1 with no ack, the block SHALL go to RESP with a timeout flagged, which gives exactly TIMEOUT_CYCLES waiting cycles.
REQ-030 If an ack arrives in the same cycle the timeout expires, the ack SHALL win and no timeout SHALL be flagged.
REQ-031 In RESP, rsp_valid SHALL be 1 for one cycle, which gives a latency of 1 cycle from ack to rsp_valid.
REQ-032 For a doubleword read, rsp_data SHALL equal mmio_in.data.
REQ-033 For a word read, rsp_data SHALL equal {32'h0, mmio_in.data[32:63]}.
REQ-034 For a write or a timeout, rsp_data SHALL be 0.
REQ-035 rsp_parity_error SHALL be 1 only for an acked read where the captured data_parity does not equal the XNOR-reduce of the captured data; it SHALL be 0 for writes.
REQ-036 If mmio_in.ack = 1 in IDLE, ISSUE or RESP, stray_ack SHALL be set and the state SHALL NOT change.
REQ-037 The minimum cycle-to-cycle spacing between back-to-back transactions SHALL be 4 cycles; the next request is accepted in the IDLE cycle that follows RESP.

Reset
REQ-038 Reset asserted in any cycle, including mid-transaction, SHALL force IDLE on the next edge.
REQ-039 Reset SHALL clear all outputs to 0 except req_ready, which SHALL become 1; the counter and stray_ack SHALL clear to 0.
REQ-040 A transaction in flight at reset SHALL be dropped with no rsp_valid, and a late ack after reset SHALL set stray_ack.

Verification
REQ-041 Doubleword write: addr 24'hFFFFFE, data 64'h0123456789ABCDEF, AFU acks 3 cycles after valid -> mmio_out.valid one cycle with odd parities, then rsp_valid one cycle after the ack with rsp_data 0 and both flags 0.
REQ-042 Word read: cfg=1, addr 0, AFU returns data 64'hXXXXXXXX_DEADBEEF with correct parity -> rsp_data 64'h00000000_DEADBEEF, rsp_parity_error 0.
REQ-043 Read returning 64'h1 with data_parity 1 -> rsp_parity_error 1.
REQ-044 TIMEOUT_CYCLES=8 with no ack -> rsp_valid 9 cycles after mmio_out.valid, rsp_timeout 1; a later ack sets stray_ack.
REQ-045 Ack in the final timeout cycle -> rsp_timeout 0 and the data is returned.
REQ-046 Reset asserted in WAIT_ACK -> req_ready 1 next cycle and no rsp_valid; back-to-back requests show a 4-cycle acceptance spacing.
